// File: rtl/gcd_datapath_if.sv
// Control and status bundle between the GCD controller and its datapath.
// The controller (master) drives register addresses, write controls and ALU
// controls; the datapath (slave) returns the zero flag and the result register.
interface gcd_datapath_if #(
    parameter int WIDTH = 32
);
    logic [4:0]       rf_read_addr1;
    logic [4:0]       rf_read_addr2;
    logic [4:0]       rf_write_addr;
    logic             rf_write_en;
    logic             rf_write_data_sel;
    logic [WIDTH-1:0] const_val;
    logic             alu_sel;
    logic [1:0]       alu_oper;
    logic             is_zero_result;
    logic [WIDTH-1:0] result;

    modport master (
        output rf_read_addr1,
        output rf_read_addr2,
        output rf_write_addr,
        output rf_write_en,
        output rf_write_data_sel,
        output const_val,
        output alu_sel,
        output alu_oper,
        input  is_zero_result,
        input  result
    );

    modport slave (
        input  rf_read_addr1,
        input  rf_read_addr2,
        input  rf_write_addr,
        input  rf_write_en,
        input  rf_write_data_sel,
        input  const_val,
        input  alu_sel,
        input  alu_oper,
        output is_zero_result,
        output result
    );
endinterface

// File: rtl/gcd_datapath.sv
// Register file plus single-cycle ALU for the GCD controller.
// R0 reads as zero, addresses at or beyond NREGS read zero and ignore writes.
// Reads are asynchronous with no write bypass, so an instruction that reads
// and writes the same register sees the old value.
module gcd_datapath #(
    parameter int WIDTH      = 32,
    parameter int NREGS      = 32,
    parameter int RESULT_REG = 1
) (
    input logic          clk,
    input logic          rst,
    gcd_datapath_if.slave dp
);
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LT   = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam logic [4:0] RES_ADDR = 5'(RESULT_REG);

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] write_data;
    logic             addr_writable;

    function automatic logic [WIDTH-1:0] rd(input logic [4:0] addr);
        if (addr == 5'd0 || int'(addr) >= NREGS) begin
            return '0;
        end
        return regs[addr];
    endfunction

    // Operand selection and ALU operation, purely combinational.
    always_comb begin
        opnd_a     = rd(dp.rf_read_addr1);
        opnd_b     = dp.alu_sel ? dp.const_val : rd(dp.rf_read_addr2);
        alu_result = '0;
        case (dp.alu_oper)
            OP_ADD:  alu_result = opnd_a + opnd_b;
            OP_SUB:  alu_result = opnd_a - opnd_b;
            OP_LT:   alu_result = {{(WIDTH-1){1'b0}}, (opnd_a < opnd_b)};
            OP_PASS: alu_result = opnd_a;
            default: alu_result = '0;
        endcase
    end

    assign write_data    = dp.rf_write_data_sel ? dp.const_val : alu_result;
    assign addr_writable = (dp.rf_write_addr != 5'd0) && (int'(dp.rf_write_addr) < NREGS);

    // Register file storage: cleared on reset, otherwise one optional write per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (dp.rf_write_en && addr_writable) begin
            regs[dp.rf_write_addr] <= write_data;
        end
    end

    // Zero flag tracks the ALU every cycle, independent of the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp.is_zero_result <= 1'b0;
        end else begin
            dp.is_zero_result <= (alu_result == '0);
        end
    end

    assign dp.result = rd(RES_ADDR);
endmodule

// File: tb/tb_gcd_datapath.sv
// Randomised and directed bench for gcd_datapath with a queue-based scoreboard.
module tb_gcd_datapath;
    localparam int W = 32;
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_LT   = 2'd2;
    localparam logic [1:0] OP_PASS = 2'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcd_datapath_if #(.WIDTH(W)) dpif ();

    gcd_datapath #(.WIDTH(W), .NREGS(32), .RESULT_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (dpif)
    );

    typedef struct {
        string        name;
        logic [W-1:0] exp;
        bit           is_flag;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [W-1:0] mon_act;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] m[32];

    // One controller cycle: drive, update the reference model, queue expectations.
    task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] wa, input logic we, input logic ws,
                        input logic [W-1:0] c, input logic as, input logic [1:0] op,
                        input string tag);
        logic [W-1:0] a, b, alu, fl;
        @(negedge clk);
        rst                    = r;
        dpif.rf_read_addr1     = a1;
        dpif.rf_read_addr2     = a2;
        dpif.rf_write_addr     = wa;
        dpif.rf_write_en       = we;
        dpif.rf_write_data_sel = ws;
        dpif.const_val         = c;
        dpif.alu_sel           = as;
        dpif.alu_oper          = op;
        a = m[a1];
        b = as ? c : m[a2];
        case (op)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_LT:   alu = (a < b) ? 1 : 0;
            default: alu = a;
        endcase
        if (r) begin
            for (int i = 0; i < 32; i++) m[i] = '0;
            fl = '0;
        end else begin
            if (we && wa != 5'd0) m[wa] = ws ? c : alu;
            fl = (alu == '0) ? 1 : 0;
        end
        sb.push_back('{name: {tag, ".zero"}, exp: fl, is_flag: 1'b1});
        sb.push_back('{name: {tag, ".result"}, exp: m[1], is_flag: 1'b0});
    endtask

    task automatic ld(input logic [4:0] wa, input logic [W-1:0] c, input string tag);
        step(1'b0, 5'd0, 5'd0, wa, 1'b1, 1'b1, c, 1'b0, OP_ADD, tag);
    endtask

    // Register probe: subtract a known value, zero flag shows equality next cycle.
    task automatic expect_reg(input logic [4:0] n, input logic [W-1:0] v, input string tag);
        step(1'b0, n, 5'd0, 5'd0, 1'b0, 1'b0, v, 1'b1, OP_SUB, tag);
    endtask

    // Monitor: after each rising edge compare everything issued for that edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                mon_e   = sb.pop_front();
                mon_act = mon_e.is_flag ? {{(W-1){1'b0}}, dpif.is_zero_result} : dpif.result;
                n_cmp++;
                if (mon_act !== mon_e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %0h expected %0h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ga, gb, rc;
        logic [4:0]   ra1, ra2, rwa;
        bit           done;
        rst = 1'b1;
        dpif.rf_read_addr1 = '0; dpif.rf_read_addr2 = '0; dpif.rf_write_addr = '0;
        dpif.rf_write_en = 1'b0; dpif.rf_write_data_sel = 1'b0; dpif.const_val = '0;
        dpif.alu_sel = 1'b0; dpif.alu_oper = OP_ADD;
        for (int i = 0; i < 32; i++) m[i] = '0;

        // Reset with a write request present: write must be dropped.
        step(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'd99, 1'b0, OP_ADD, "rst_init");
        ld(5'd1, 32'd5, "pre_r1");
        ld(5'd9, 32'd77, "pre_r9");
        step(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 32'd3, 1'b0, OP_PASS, "rst_mid");
        for (int n = 1; n < 32; n++) expect_reg(5'(n), 32'd0, "rst_clear");

        ld(5'd1, 32'd48, "ld_r1");
        ld(5'd2, 32'd18, "ld_r2");
        expect_reg(5'd1, 32'd48, "chk_r1_48");
        expect_reg(5'd2, 32'd18, "chk_r2_18");
        ld(5'd0, 32'd7, "ld_r0");
        expect_reg(5'd0, 32'd0, "chk_r0");

        step(1'b0, 5'd1, 5'd2, 5'd1, 1'b1, 1'b0, 32'd0, 1'b0, OP_SUB, "sub_wb");
        expect_reg(5'd1, 32'd30, "chk_r1_30");
        step(1'b0, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, OP_SUB, "sub_self");

        step(1'b0, 5'd2, 5'd1, 5'd3, 1'b1, 1'b0, 32'd0, 1'b0, OP_LT, "lt_wb");
        expect_reg(5'd3, 32'd1, "chk_r3_1");
        step(1'b0, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 32'd0, 1'b0, OP_PASS, "pass_wb");
        expect_reg(5'd6, 32'd30, "chk_r6_30");
        step(1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 32'd30, 1'b1, OP_SUB, "sub_const");

        // R4 is 0 here; writing 9 while passing R4 must expose the old 0.
        step(1'b0, 5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 32'd9, 1'b0, OP_PASS, "hazard");
        expect_reg(5'd4, 32'd9, "chk_r4_9");

        ld(5'd5, 32'd0, "ld_r5");
        step(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 32'd1, 1'b1, OP_SUB, "wrap_sub");
        expect_reg(5'd5, 32'hFFFF_FFFF, "chk_r5_max");
        step(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 32'd1, 1'b1, OP_ADD, "wrap_add");
        expect_reg(5'd5, 32'd0, "chk_r5_0");
        step(1'b0, 5'd1, 5'd2, 5'd1, 1'b0, 1'b1, 32'd123, 1'b0, OP_PASS, "we_off");
        expect_reg(5'd1, 32'd30, "chk_we_off");

        // Subtractive GCD driven by the bench's own controller model.
        ld(5'd1, 32'd48, "gcd_a");
        ld(5'd2, 32'd18, "gcd_b");
        done = 1'b0;
        for (int it = 0; it < 64 && !done; it++) begin
            ga = m[1];
            gb = m[2];
            if (ga == gb) begin
                step(1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, OP_SUB, "gcd_term");
                done = 1'b1;
            end else if (ga > gb) begin
                step(1'b0, 5'd1, 5'd2, 5'd1, 1'b1, 1'b0, 32'd0, 1'b0, OP_SUB, "gcd_a_sub");
            end else begin
                step(1'b0, 5'd2, 5'd1, 5'd2, 1'b1, 1'b0, 32'd0, 1'b0, OP_SUB, "gcd_b_sub");
            end
        end
        expect_reg(5'd1, 32'd6, "gcd_r1_6");

        // Random traffic on a small address window to force collisions.
        for (int k = 0; k < 400; k++) begin
            ra1 = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            ra2 = 5'($urandom_range(0, 7));
            rwa = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0:       rc = 32'd0;
                1:       rc = 32'd1;
                2:       rc = 32'hFFFF_FFFF;
                3:       rc = 32'($urandom_range(0, 20));
                default: rc = $urandom;
            endcase
            step(($urandom_range(0, 59) == 0), ra1, ra2, rwa, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), rc, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), "rand");
        end

        @(posedge clk);
        #3;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
